// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the two-requester add/sub arbiter.
package alu_arb_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned RES_W  = 5;
    localparam int unsigned CNT_W  = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation captured from the granted requester.
    typedef struct packed {
        logic              id;
        logic              op;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } op_req_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational 4-bit add/subtract; subtraction wraps modulo 32.
module alu_addsub
    import alu_arb_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic              op,
    output logic [RES_W-1:0]  y
);

    always_comb begin
        y = RES_W'({1'b0, a}) + RES_W'({1'b0, b});
        if (op == OP_SUB) begin
            y = RES_W'({1'b0, a}) - RES_W'({1'b0, b});
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one add/sub ALU between two requesters;
// one operation in flight, result held until the consumer accepts it.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    input  logic              req0_op,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    input  logic              req1_op,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [RES_W-1:0]  resp_result,
    input  logic              resp_ready,
    output logic [CNT_W-1:0]  op_count
);

    state_t           state;
    logic             last;
    op_req_t          cur;
    logic             grant_id;
    logic [1:0]       grant_mask;
    logic [RES_W-1:0] alu_y;

    // Lone requester wins outright; on contention the one not granted last wins.
    always_comb begin
        grant_id = ~last;
        case (req_valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            default: grant_id = ~last;
        endcase
        grant_mask = grant_id ? 2'b10 : 2'b01;
        req_ready  = 2'b00;
        if (reset && (state == IDLE)) begin
            req_ready = grant_mask & req_valid;
        end
    end

    alu_addsub u_alu (
        .a  (cur.a),
        .b  (cur.b),
        .op (cur.op),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            last        <= 1'b1;
            cur         <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            op_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        if (grant_id) begin
                            cur <= '{id: 1'b1, op: req1_op, a: req1_a, b: req1_b};
                        end else begin
                            cur <= '{id: 1'b0, op: req0_op, a: req0_a, b: req0_b};
                        end
                        last  <= grant_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result <= alu_y;
                    resp_id     <= cur.id;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        op_count   <= op_count + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed operations, contention,
// backpressure, mid-operation reset and counter wrap.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       req0_op, req1_op;
    logic       resp_valid;
    logic       resp_id;
    logic [4:0] resp_result;
    logic       resp_ready;
    logic [7:0] op_count;

    typedef struct packed {
        logic       id;
        logic [4:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_resp = 0;

    alu_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_op     (req0_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_op     (req1_op),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_ready  (resp_ready),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every accepted response must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && resp_valid && resp_ready) begin
            n_resp++;
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_id", int'(resp_id), int'(e.id));
                chk("resp_result", int'(resp_result), int'(e.res));
            end
        end
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = 2'b00;
        to_drive();
        to_drive();
        reset = 1'b1;
    endtask

    // Caller sets operands at a drive point; runs one full 3-cycle operation.
    task automatic issue(input logic [1:0] v, input logic [1:0] exp_rdy,
                         input logic exp_id, input logic [4:0] exp_res);
        req_valid = v;
        @(negedge clk);
        chk("req_ready_grant", int'(req_ready), int'(exp_rdy));
        exp_q.push_back('{id: exp_id, res: exp_res});
        to_drive();
        @(negedge clk);
        chk("req_ready_exec", int'(req_ready), 0);
        to_drive();
        @(negedge clk);
        chk("resp_valid_latency", int'(resp_valid), 1);
        to_drive();
    endtask

    initial begin
        int n_before;
        reset      = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        req0_a = 4'd0; req0_b = 4'd0; req0_op = 1'b0;
        req1_a = 4'd0; req1_b = 4'd0; req1_op = 1'b0;
        to_drive();
        @(negedge clk);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_id", int'(resp_id), 0);
        chk("rst_resp_result", int'(resp_result), 0);
        chk("rst_op_count", int'(op_count), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        to_drive();
        req_valid = 2'b00;
        reset     = 1'b1;
        to_drive();

        // Single add
        req0_a = 4'd3; req0_b = 4'd1; req0_op = 1'b0;
        issue(2'b01, 2'b01, 1'b0, 5'd4);
        chk("op_count_1", int'(op_count), 1);

        // Subtract wrap, then add with carry
        req1_a = 4'd0; req1_b = 4'd1; req1_op = 1'b1;
        issue(2'b10, 2'b10, 1'b1, 5'h1F);
        req1_a = 4'd15; req1_b = 4'd15; req1_op = 1'b0;
        issue(2'b10, 2'b10, 1'b1, 5'd30);
        chk("op_count_3", int'(op_count), 3);

        // Backpressure: 7-9 = 0x1E held while operands churn
        resp_ready = 1'b0;
        req0_a = 4'd7; req0_b = 4'd9; req0_op = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        chk("bp_req_ready", int'(req_ready), 2'b01);
        exp_q.push_back('{id: 1'b0, res: 5'h1E});
        to_drive();
        req0_a = 4'd2;
        to_drive();
        for (int i = 0; i < 5; i++) begin
            req0_a    = 4'(i + 1);
            req0_b    = 4'(i * 3);
            req0_op   = i[0];
            req_valid = 2'b11;
            @(negedge clk);
            chk("bp_resp_valid", int'(resp_valid), 1);
            chk("bp_resp_result", int'(resp_result), 5'h1E);
            chk("bp_resp_id", int'(resp_id), 0);
            chk("bp_req_ready", int'(req_ready), 0);
            to_drive();
        end
        n_before   = n_resp;
        resp_ready = 1'b1;
        to_drive();
        req_valid = 2'b00;
        @(negedge clk);
        chk("bp_resp_cleared", int'(resp_valid), 0);
        chk("bp_one_resp", n_resp, n_before + 1);
        chk("op_count_4", int'(op_count), 4);
        to_drive();

        // Reset during EXEC abandons the operation
        n_before = n_resp;
        req1_a = 4'd4; req1_b = 4'd4; req1_op = 1'b0;
        req_valid = 2'b10;
        @(negedge clk);
        chk("rm_req_ready", int'(req_ready), 2'b10);
        to_drive();
        reset = 1'b0;
        to_drive();
        @(negedge clk);
        chk("rm_resp_valid", int'(resp_valid), 0);
        chk("rm_op_count", int'(op_count), 0);
        chk("rm_req_ready_in_reset", int'(req_ready), 0);
        to_drive();
        reset     = 1'b1;
        req_valid = 2'b00;
        repeat (3) to_drive();
        chk("rm_no_resp", n_resp, n_before);
        chk("rm_resp_valid_idle", int'(resp_valid), 0);
        issue(2'b10, 2'b10, 1'b1, 5'd8);
        chk("rm_op_count_after", int'(op_count), 1);

        // Contention after reset: 0,1,0,1
        do_reset();
        req0_a = 4'd5; req0_b = 4'd2; req0_op = 1'b1;
        req1_a = 4'd9; req1_b = 4'd8; req1_op = 1'b0;
        issue(2'b11, 2'b01, 1'b0, 5'd3);
        issue(2'b11, 2'b10, 1'b1, 5'd17);
        issue(2'b11, 2'b01, 1'b0, 5'd3);
        issue(2'b11, 2'b10, 1'b1, 5'd17);
        chk("rr_op_count", int'(op_count), 4);

        // Counter wrap after 256 completions
        do_reset();
        req1_op = 1'b0;
        for (int i = 0; i < 256; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            a = 4'(i);
            b = 4'(i * 7);
            req1_a = a;
            req1_b = b;
            issue(2'b10, 2'b10, 1'b1, 5'(int'(a) + int'(b)));
            if (i == 254) chk("op_count_255", int'(op_count), 255);
        end
        chk("op_count_wrap", int'(op_count), 0);
        req_valid = 2'b00;
        repeat (2) to_drive();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- req_valid  input  2  bit i: requester i presents an operation.
- req_ready  output  2  bit i: requester i's operation is accepted this cycle.
- req0_a, req0_b  input  4 each  requester 0 operands (unsigned).
- req0_op  input  1  requester 0 opcode: 0 = add, 1 = subtract.
- req1_a, req1_b  input  4 each  requester 1 operands (unsigned).
- req1_op  input  1  requester 1 opcode: 0 = add, 1 = subtract.
- resp_valid  output  1  a result is presented.
- resp_id  output  1  requester index that owns the result.
- resp_result  output  5  operation result.
- resp_ready  input  1  consumer accepts the result this cycle.
- op_count  output  8  count of completed operations.

Function
REQ-002 The block SHALL share one add/sub ALU between two requesters using an FSM with states IDLE, EXEC and RESP.
REQ-003 In IDLE, when any req_valid bit is set, the block SHALL grant exactly one requester: the only valid one if one is valid; if both are valid, the one not granted last.
REQ-004 req_ready SHALL be one-hot or zero; it SHALL be nonzero only in IDLE and only for the granted requester with req_valid high (combinational from state, req_valid and the round-robin pointer).
REQ-005 On a grant, the block SHALL capture the winner's a, b, op and index, update the last-grant pointer, and go to EXEC.
REQ-006 In EXEC, the block SHALL compute from the captured operands, register the result into resp_result, and go to RESP.
REQ-007 Add SHALL give {1'b0,a}+{1'b0,b} (carry in bit 4). Subtract SHALL give ({1'b0,a}-{1'b0,b}) mod 32, so 0-1 = 5'h1F.
REQ-008 In RESP, resp_valid SHALL be 1, and resp_result and resp_id SHALL be held stable until resp_ready=1.
REQ-009 When RESP and resp_ready are both 1 on a clock edge, the block SHALL return to IDLE and increment op_count (255 wraps to 0).
REQ-010 Latency: an operation accepted at edge N SHALL present resp_valid at edge N+2; at most one operation is in flight, so the minimum issue interval is 3 cycles.
REQ-011 In EXEC and RESP, the block SHALL ignore req_valid and requester operand changes.
REQ-012 A requester that drops req_valid before being granted SHALL cause no action.
REQ-013 resp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-014 With reset=0 at a clock edge, the block SHALL enter IDLE with resp_valid=0, resp_id=0, resp_result=0, op_count=0, and last-grant pointer=1 (so requester 0 wins the first contention).
REQ-015 Reset in EXEC or RESP SHALL abandon the in-flight operation: no response is delivered and op_count does not increment.
REQ-016 While reset=0, req_ready SHALL be 2'b00.

Structure
REQ-017 A shared package alu_arb_pkg SHALL hold the FSM state type, the OP_ADD/OP_SUB constants, and the operand/result width constants (4, 5).
REQ-018 The ALU SHALL be a separate sub-module alu_addsub: combinational, with inputs a[3:0], b[3:0], op and output y[4:0]. The arbiter SHALL own the result register.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single add: req0 a=3, b=1, op=0 -> req_ready=01; 2 edges later resp_valid=1, resp_id=0, resp_result=4; op_count=1 after resp_ready.
- Subtract wrap and carry: req1 a=0, b=1, op=1 -> resp_result=5'h1F, resp_id=1. Then a=15, b=15, op=0 -> resp_result=30.
- Contention round-robin: both valid continuously after reset -> grant order 0,1,0,1; resp_id sequence matches.
- Backpressure: resp_ready=0 for 5 cycles in RESP while req0 operands change -> resp_result stable, req_ready=00, one response only after resp_ready=1.
- Reset mid-operation: reset=0 during EXEC -> next cycle resp_valid=0, op_count=0; the next request after reset completes normally.
- Counter wrap: 256 completed ops -> op_count returns to 0.
